// File: rtl/apb_manager.sv
// Single-outstanding APB requester: valid/ready command in, APB SETUP/ACCESS out,
// valid/ready response back, with a wait-state watchdog on the ACCESS phase.
module apb_manager #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [AddrWidth-1:0] cmdAddr,
  input  logic                 cmdWrite,
  input  logic [DataWidth-1:0] cmdWData,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DataWidth-1:0] rspRData,
  output logic                 rspErr,
  output logic                 rspTimeout,
  output logic                 sel,
  output logic                 enable,
  output logic [AddrWidth-1:0] addr,
  output logic                 write,
  output logic [DataWidth-1:0] wData,
  input  logic [DataWidth-1:0] rData,
  input  logic                 readyOut,
  input  logic                 subErr
);
  localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LAST = (TimeoutCycles > 0) ? CW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          cmd_ready_d, sel_d, enable_d, rsp_valid_d;

  // wait_cnt holds the number of ACCESS cycles already spent waiting
  assign timeout_hit = (TimeoutCycles != 0) && (state_q == ACCESS) && !readyOut &&
                       (wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      cmdReady <= 1'b1;
      sel      <= 1'b0;
      enable   <= 1'b0;
      rspValid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmdReady <= cmd_ready_d;
      sel      <= sel_d;
      enable   <= enable_d;
      rspValid <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmdValid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (readyOut || timeout_hit) state_d = RESP;
      RESP:    if (rspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they register in step with it
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    sel_d       = (state_d == SETUP) || (state_d == ACCESS);
    enable_d    = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      addr       <= '0;
      write      <= 1'b0;
      wData      <= '0;
      wait_cnt   <= '0;
      rspRData   <= '0;
      rspErr     <= 1'b0;
      rspTimeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmdValid) begin
          addr     <= cmdAddr;
          write    <= cmdWrite;
          wData    <= cmdWData;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (readyOut) begin
            rspRData   <= write ? '0 : rData;
            rspErr     <= subErr;
            rspTimeout <= 1'b0;
          end else begin
            if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
            if (timeout_hit) begin
              rspRData   <= '0;
              rspErr     <= 1'b1;
              rspTimeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
